// File: rtl/gray_rx_decoder.sv
// Receive-side Gray-count checker: two-stage Gray-to-binary decode and +1 step
// verification, with a small lock FSM and a saturating step-error counter.
module gray_rx_decoder #(
    parameter int CBITS     = 9,
    parameter int ERR_LIMIT = 3,
    parameter int RELOCK    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             zero_seen,
    output logic             wrap,
    output logic             step_err,
    output logic             hold,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(RELOCK + 1);
    localparam logic [EW-1:0]    ELIM_M1 = EW'(ERR_LIMIT - 1);
    localparam logic [GW-1:0]    GLIM_M1 = GW'(RELOCK - 1);
    localparam logic [CBITS-1:0] ONE     = CBITS'(1);
    localparam logic [CBITS-1:0] MAXV    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CBITS-1:0] g_q_reg;
    logic             v1_reg;
    logic [CBITS-1:0] prev_reg;
    logic [EW-1:0]    ecnt_reg, ecnt_next;
    logic [GW-1:0]    gcnt_reg, gcnt_next;
    logic [CBITS-1:0] b;
    logic [CBITS-1:0] delta;
    logic             zero_next, wrap_next, err_next, hold_next;
    logic [7:0]       err_cnt_next;

    // Each binary bit is the XOR of all Gray bits at and above it.
    generate
        for (genvar gi = 0; gi < CBITS; gi++) begin : g_decode
            assign b[gi] = ^g_q_reg[CBITS-1:gi];
        end
    endgenerate

    // Modular difference; unsigned wrap makes 2^CBITS-1 -> 0 a +1 step.
    assign delta = b - prev_reg;

    always_comb begin
        state_next = state_reg;
        ecnt_next  = ecnt_reg;
        gcnt_next  = gcnt_reg;
        zero_next  = 1'b0;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        hold_next  = 1'b0;
        if (v1_reg) begin
            zero_next = (b == '0);
            case (state_reg)
                IDLE: begin
                    state_next = TRACK;
                end
                TRACK: begin
                    if (delta == ONE) begin
                        ecnt_next = '0;
                        wrap_next = (prev_reg == MAXV);
                    end else if (delta == '0) begin
                        hold_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                        if (ecnt_reg == ELIM_M1) begin
                            state_next = LOST;
                            ecnt_next  = '0;
                            gcnt_next  = '0;
                        end else begin
                            ecnt_next = ecnt_reg + 1'b1;
                        end
                    end
                end
                LOST: begin
                    if (delta == ONE) begin
                        wrap_next = (prev_reg == MAXV);
                        if (gcnt_reg == GLIM_M1) begin
                            state_next = TRACK;
                            gcnt_next  = '0;
                            ecnt_next  = '0;
                        end else begin
                            gcnt_next = gcnt_reg + 1'b1;
                        end
                    end else if (delta == '0) begin
                        hold_next = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        gcnt_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    ecnt_next  = '0;
                    gcnt_next  = '0;
                end
            endcase
        end
    end

    assign err_cnt_next = (err_next && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            g_q_reg   <= '0;
            v1_reg    <= 1'b0;
            prev_reg  <= '0;
            ecnt_reg  <= '0;
            gcnt_reg  <= '0;
            bin_out   <= '0;
            bin_vld   <= 1'b0;
            zero_seen <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
            hold      <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            v1_reg <= gray_vld;
            if (gray_vld) begin
                g_q_reg <= gray_in;
            end
            if (v1_reg) begin
                bin_out  <= b;
                prev_reg <= b;
            end
            bin_vld   <= v1_reg;
            zero_seen <= zero_next;
            wrap      <= wrap_next;
            step_err  <= err_next;
            hold      <= hold_next;
            state_reg <= state_next;
            ecnt_reg  <= ecnt_next;
            gcnt_reg  <= gcnt_next;
            locked    <= (state_next == TRACK);
            err_cnt   <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed and randomized checks of gray_rx_decoder against a sample-level
// model of the step-checking and lock rules.
module tb_gray_rx_decoder;

    localparam int CB   = 9;
    localparam int MOD  = 512;
    localparam int ELIM = 3;
    localparam int RLCK = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CB-1:0] gray_in;
    logic          gray_vld;
    logic [CB-1:0] bin_out;
    logic          bin_vld, zero_seen, wrap, step_err, hold, locked;
    logic [7:0]    err_cnt;

    gray_rx_decoder #(.CBITS(CB), .ERR_LIMIT(ELIM), .RELOCK(RLCK)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld),
        .bin_out(bin_out), .bin_vld(bin_vld), .zero_seen(zero_seen), .wrap(wrap),
        .step_err(step_err), .hold(hold), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 = not yet seen a sample, 1 = tracking, 2 = lost.
    int m_mode, m_prev, m_ecnt, m_gcnt, m_errs;
    int s1_vld, s1_val;
    int e_bin, e_vld, e_zero, e_wrap, e_err, e_hold, e_lock;
    int n_vld, n_zero, n_wrap, n_err, n_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_ecnt = 0; m_gcnt = 0; m_errs = 0;
        s1_vld = 0; s1_val = 0;
        e_bin = 0; e_vld = 0; e_zero = 0; e_wrap = 0; e_err = 0; e_hold = 0; e_lock = 0;
    endtask

    task automatic clear_counts();
        n_vld = 0; n_zero = 0; n_wrap = 0; n_err = 0; n_hold = 0;
    endtask

    task automatic model_sample(input int v);
        int d;
        d = ((v - m_prev) % MOD + MOD) % MOD;
        e_zero = (v == 0);
        if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            e_hold = (d == 0);
            e_wrap = (d == 1) && (m_prev == MOD - 1);
            e_err  = (d != 0) && (d != 1);
            if (e_err && m_errs < 255) m_errs++;
            if (m_mode == 1) begin
                if (d == 1) m_ecnt = 0;
                else if (e_err) begin
                    m_ecnt++;
                    if (m_ecnt == ELIM) begin m_mode = 2; m_ecnt = 0; m_gcnt = 0; end
                end
            end else begin
                if (d == 1) begin
                    m_gcnt++;
                    if (m_gcnt == RLCK) begin m_mode = 1; m_gcnt = 0; end
                end else if (e_err) m_gcnt = 0;
            end
        end
        m_prev = v;
        e_bin  = v;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".bin_vld"},   32'(bin_vld),   e_vld);
        chk({pfx, ".bin_out"},   32'(bin_out),   e_bin);
        chk({pfx, ".zero_seen"}, 32'(zero_seen), e_zero);
        chk({pfx, ".wrap"},      32'(wrap),      e_wrap);
        chk({pfx, ".step_err"},  32'(step_err),  e_err);
        chk({pfx, ".hold"},      32'(hold),      e_hold);
        chk({pfx, ".locked"},    32'(locked),    e_lock);
        chk({pfx, ".err_cnt"},   32'(err_cnt),   m_errs);
    endtask

    // One clock: drive an input, advance the model by the sample leaving stage 1.
    task automatic cyc(input bit vld, input int val, input string pfx);
        int v;
        v = val % MOD;
        @(negedge clk);
        gray_vld = vld;
        gray_in  = CB'(v ^ (v >> 1));
        @(posedge clk);
        e_vld = 0; e_zero = 0; e_wrap = 0; e_err = 0; e_hold = 0;
        if (s1_vld != 0) begin
            e_vld = 1;
            model_sample(s1_val);
        end
        e_lock = (m_mode == 1);
        s1_vld = vld;
        s1_val = v;
        #1;
        check_outputs(pfx);
        if (bin_vld) begin
            n_vld++;
            $display("%s sample bin=%0d zero=%0b wrap=%0b err=%0b hold=%0b locked=%0b err_cnt=%0d",
                     pfx, bin_out, zero_seen, wrap, step_err, hold, locked, err_cnt);
        end
        if (bin_vld && zero_seen) n_zero++;
        if (bin_vld && wrap)      n_wrap++;
        if (bin_vld && step_err)  n_err++;
        if (bin_vld && hold)      n_hold++;
    endtask

    // Caller positions at a negedge; reset is asserted between clock edges.
    task automatic apply_reset(input string pfx);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({pfx, ".async"});
        @(posedge clk);
        #1;
        check_outputs({pfx, ".held"});
        @(negedge clk);
        gray_vld = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int cur;
        rst = 1'b0; gray_vld = 1'b0; gray_in = '0;
        model_reset();
        clear_counts();

        // Power-on reset
        @(negedge clk);
        apply_reset("t0");

        // 1: dense count 0..600 through the wrap
        clear_counts();
        for (int v = 0; v <= 600; v++) cyc(1'b1, v, "t1");
        repeat (2) cyc(1'b0, 0, "t1");
        chk("t1.pulses", n_vld, 601);
        chk("t1.zeros", n_zero, 2);
        chk("t1.wraps", n_wrap, 1);
        chk("t1.errs", n_err, 0);

        // 2: repeated sample gives a hold
        @(negedge clk); apply_reset("t2");
        clear_counts();
        cyc(1'b1, 10, "t2"); cyc(1'b1, 11, "t2"); cyc(1'b1, 11, "t2"); cyc(1'b1, 12, "t2");
        repeat (2) cyc(1'b0, 0, "t2");
        chk("t2.holds", n_hold, 1);
        chk("t2.errs", n_err, 0);
        chk("t2.locked", 32'(locked), 1);

        // 3: isolated jumps with recovery steps
        @(negedge clk); apply_reset("t3");
        clear_counts();
        cyc(1'b1, 20, "t3"); cyc(1'b1, 21, "t3"); cyc(1'b1, 40, "t3");
        cyc(1'b1, 41, "t3"); cyc(1'b1, 90, "t3"); cyc(1'b1, 91, "t3");
        repeat (2) cyc(1'b0, 0, "t3");
        chk("t3.errs", n_err, 2);
        chk("t3.err_cnt", 32'(err_cnt), 2);
        chk("t3.locked", 32'(locked), 1);

        // 4: lose lock, relock, then a backward 0 -> 511 step
        @(negedge clk); apply_reset("t4");
        cyc(1'b1, 5, "t4"); cyc(1'b1, 100, "t4"); cyc(1'b1, 200, "t4"); cyc(1'b1, 300, "t4");
        cyc(1'b0, 0, "t4"); cyc(1'b0, 0, "t4");
        chk("t4.lost", 32'(locked), 0);
        cyc(1'b1, 301, "t4"); cyc(1'b1, 302, "t4");
        cyc(1'b0, 0, "t4"); cyc(1'b0, 0, "t4");
        chk("t4.relocked", 32'(locked), 1);
        clear_counts();
        cyc(1'b1, 0, "t4"); cyc(1'b0, 0, "t4"); cyc(1'b0, 0, "t4");
        cyc(1'b1, 511, "t4"); cyc(1'b0, 0, "t4"); cyc(1'b0, 0, "t4");
        chk("t4.back_err", 32'(step_err) + 32'(n_err), 2);

        // 5: reset with samples in flight drops them
        @(negedge clk); apply_reset("t5a");
        cyc(1'b1, 40, "t5");
        @(negedge clk);
        gray_vld = 1'b1;
        gray_in  = CB'(41 ^ (41 >> 1));
        apply_reset("t5");
        clear_counts();
        repeat (3) cyc(1'b0, 0, "t5");
        chk("t5.no_pulse", n_vld, 0);
        cyc(1'b1, 77, "t5"); cyc(1'b0, 0, "t5"); cyc(1'b0, 0, "t5");
        chk("t5.first", 32'(bin_out), 77);
        chk("t5.errs", n_err, 0);

        // 6: gapped valids, then saturate the error counter
        @(negedge clk); apply_reset("t6");
        clear_counts();
        for (int v = 0; v <= 5; v++) begin
            cyc(1'b1, v, "t6"); cyc(1'b0, 0, "t6"); cyc(1'b0, 0, "t6");
        end
        chk("t6.pulses", n_vld, 6);
        chk("t6.errs", n_err, 0);
        for (int i = 0; i < 300; i++) cyc(1'b1, (i % 2 == 1) ? 256 : 0, "t6s");
        repeat (2) cyc(1'b0, 0, "t6s");
        chk("t6.sat", 32'(err_cnt), 255);

        // Randomized traffic: mostly +1 steps, some repeats, some jumps, random gaps
        @(negedge clk); apply_reset("tr");
        cur = $urandom_range(0, MOD - 1);
        for (int i = 0; i < 400; i++) begin
            bit vld;
            int r;
            vld = ($urandom_range(0, 3) != 0);
            if (vld) begin
                r = $urandom_range(0, 9);
                if (r < 7)       cur = (cur + 1) % MOD;
                else if (r == 8) cur = $urandom_range(0, MOD - 1);
                else if (r == 9) cur = (cur + MOD - 1) % MOD;
            end
            cyc(vld, cur, "tr");
        end
        repeat (2) cyc(1'b0, 0, "tr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
